// File: rtl/instr_fetch_unit_if.sv
// Memory-side bus of the fetch unit: enable/read strobe, address,
// returned data and ready.
interface instr_fetch_unit_if;
  logic       mem_en;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] mem_address;
  logic [7:0] mem_data_in;
  logic       mem_ready;

  modport master (
    output mem_en,
    output mem_read,
    output mem_write,
    output mem_address,
    input  mem_data_in,
    input  mem_ready
  );

  modport slave (
    input  mem_en,
    input  mem_read,
    input  mem_write,
    input  mem_address,
    output mem_data_in,
    output mem_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads one byte per instruction
// from RAM and hands it to decode over a valid/accept handshake.
module instr_fetch_unit #(
  parameter logic [7:0] RESET_PC = 8'd0,
  parameter int         MAX_WAIT = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  instr_fetch_unit_if.master         mem,
  input  logic                       pc_load,
  input  logic [7:0]                 pc_load_value,
  input  logic                       halt,
  output logic                       instr_valid,
  output logic [7:0]                 instr,
  output logic [7:0]                 instr_pc,
  input  logic                       instr_accept,
  output logic [7:0]                 pc,
  output logic                       halted,
  output logic                       fetch_error
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    HALTED
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] addr_q, addr_d;
  logic       en_q, en_d;
  logic       valid_q, valid_d;
  logic [7:0] instr_q, instr_d;
  logic [7:0] ipc_q, ipc_d;
  logic       halted_q, halted_d;
  logic       err_q, err_d;
  logic [7:0] wait_q, wait_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      en_q     <= 1'b0;
      valid_q  <= 1'b0;
      instr_q  <= 8'h00;
      ipc_q    <= 8'h00;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
      wait_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      en_q     <= en_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      ipc_q    <= ipc_d;
      halted_q <= halted_d;
      err_q    <= err_d;
      wait_q   <= wait_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    en_d     = en_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    ipc_d    = ipc_q;
    halted_d = halted_q;
    err_d    = 1'b0;
    wait_d   = wait_q;
    unique case (state_q)
      IDLE: begin
        if (pc_load) begin
          pc_d = pc_load_value;
        end else if (halt) begin
          state_d  = HALTED;
          halted_d = 1'b1;
        end else begin
          state_d = REQ;
          addr_d  = pc_q;
          en_d    = 1'b1;
          wait_d  = 8'h00;
        end
      end
      REQ: begin
        if (pc_load) begin
          en_d    = 1'b0;
          pc_d    = pc_load_value;
          state_d = IDLE;
        end else if (mem.mem_ready) begin
          instr_d = mem.mem_data_in;
          ipc_d   = pc_q;
          pc_d    = pc_q + 8'd1;
          valid_d = 1'b1;
          en_d    = 1'b0;
          state_d = HOLD;
        end else begin
          wait_d = wait_q + 8'd1;
          // give up and retry the same address after a short gap
          if (wait_q == WAIT_LAST) begin
            err_d   = 1'b1;
            en_d    = 1'b0;
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        if (pc_load) begin
          valid_d = 1'b0;
          pc_d    = pc_load_value;
          state_d = IDLE;
        end else if (instr_accept) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      HALTED: begin
        if (pc_load) begin
          pc_d     = pc_load_value;
          halted_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem.mem_en      = en_q;
  assign mem.mem_read    = en_q;
  assign mem.mem_write   = 1'b0;
  assign mem.mem_address = addr_q;

  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign pc          = pc_q;
  assign halted      = halted_q;
  assign fetch_error = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: RAM model with 2-edge ready,
// scoreboard of expected {pc, byte} fetches, directed protocol checks.
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       pc_load;
  logic [7:0] pc_load_value;
  logic       halt;
  logic       instr_valid;
  logic [7:0] instr;
  logic [7:0] instr_pc;
  logic       instr_accept;
  logic [7:0] pc;
  logic       halted;
  logic       fetch_error;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .RESET_PC (8'd0),
    .MAX_WAIT (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mem           (bus),
    .pc_load       (pc_load),
    .pc_load_value (pc_load_value),
    .halt          (halt),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_accept  (instr_accept),
    .pc            (pc),
    .halted        (halted),
    .fetch_error   (fetch_error)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [256];
  logic [7:0] dout;
  logic       rdy;
  logic       cnt;
  bit         stuck;

  always @(posedge clk) begin
    if (!bus.mem_en || stuck) begin
      cnt <= 1'b0;
      rdy <= 1'b0;
    end else if (!cnt) begin
      cnt <= 1'b1;
    end else begin
      rdy  <= 1'b1;
      dout <= ram[bus.mem_address];
    end
  end

  assign bus.mem_ready   = rdy;
  assign bus.mem_data_in = dout;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [15:0] sb [$];
  logic        pv = 1'b0;

  always @(negedge clk) begin
    if (instr_valid === 1'b1 && !pv) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 16'(instr_pc), 16'hFFFF);
      end else begin
        logic [15:0] e;
        e = sb.pop_front();
        check("sb_instr_pc", 16'(instr_pc), 16'(e[15:8]));
        check("sb_instr", 16'(instr), 16'(e[7:0]));
      end
    end
    pv <= (instr_valid === 1'b1);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] a);
    sb.push_back({a, ram[a]});
  endtask

  task automatic wait_req(input logic [7:0] a);
    int n = 0;
    while (bus.mem_en !== 1'b1 && n < 12) begin
      step();
      n++;
    end
    check("req_seen", 16'(bus.mem_en), 16'd1);
    check("req_addr", 16'(bus.mem_address), 16'(a));
  endtask

  task automatic wait_valid();
    int n = 0;
    while (instr_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("valid_seen", 16'(instr_valid), 16'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'(i * 7 + 3);
    ram[0]        = 8'hA3;
    reset         = 1'b1;
    pc_load       = 1'b0;
    pc_load_value = 8'h00;
    halt          = 1'b0;
    instr_accept  = 1'b1;
    stuck         = 1'b0;
    step();
    step();
    check("rst_en", 16'(bus.mem_en), 16'd0);
    check("rst_read", 16'(bus.mem_read), 16'd0);
    check("rst_addr", 16'(bus.mem_address), 16'h00);
    check("rst_valid", 16'(instr_valid), 16'd0);
    check("rst_pc", 16'(pc), 16'h00);
    check("rst_halted", 16'(halted), 16'd0);
    check("rst_err", 16'(fetch_error), 16'd0);
    reset = 1'b0;

    push(8'h00);
    step();
    check("t1_en", 16'(bus.mem_en), 16'd1);
    check("t1_read", 16'(bus.mem_read), 16'd1);
    check("t1_write", 16'(bus.mem_write), 16'd0);
    check("t1_addr", 16'(bus.mem_address), 16'h00);
    step();
    check("t1_nv1", 16'(instr_valid), 16'd0);
    step();
    check("t1_nv2", 16'(instr_valid), 16'd0);
    step();
    check("t1_valid", 16'(instr_valid), 16'd1);
    check("t1_pc", 16'(pc), 16'h01);
    check("t1_en_off", 16'(bus.mem_en), 16'd0);

    instr_accept = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_valid", 16'(instr_valid), 16'd1);
      check("t2_instr", 16'(instr), 16'hA3);
      check("t2_en", 16'(bus.mem_en), 16'd0);
      check("t2_pc", 16'(pc), 16'h01);
    end
    instr_accept = 1'b1;
    push(8'h01);
    step();
    check("t2_gap", 16'(bus.mem_en), 16'd0);
    check("t2_vdrop", 16'(instr_valid), 16'd0);
    step();
    check("t2_en", 16'(bus.mem_en), 16'd1);
    check("t2_addr", 16'(bus.mem_address), 16'h01);
    wait_valid();

    wait_req(8'h02);
    pc_load       = 1'b1;
    pc_load_value = 8'h21;
    step();
    pc_load = 1'b0;
    check("t3_abort_en", 16'(bus.mem_en), 16'd0);
    check("t3_abort_pc", 16'(pc), 16'h21);
    check("t3_abort_nv", 16'(instr_valid), 16'd0);
    wait_req(8'h21);
    push(8'h21);
    wait_valid();
    pc_load = 1'b1;
    step();
    pc_load = 1'b0;
    check("t3_hold_nv", 16'(instr_valid), 16'd0);
    check("t3_hold_pc", 16'(pc), 16'h21);
    wait_req(8'h21);
    push(8'h21);
    wait_valid();

    pc_load       = 1'b1;
    pc_load_value = 8'hFF;
    step();
    pc_load = 1'b0;
    check("t4_pc", 16'(pc), 16'hFF);
    wait_req(8'hFF);
    push(8'hFF);
    wait_valid();
    check("t4_wrap_pc", 16'(pc), 16'h00);

    stuck = 1'b1;
    wait_req(8'h00);
    for (int i = 0; i < 7; i++) begin
      step();
      check("t5_en_hold", 16'(bus.mem_en), 16'd1);
      check("t5_no_err", 16'(fetch_error), 16'd0);
    end
    step();
    check("t5_err", 16'(fetch_error), 16'd1);
    check("t5_en_low", 16'(bus.mem_en), 16'd0);
    check("t5_pc_kept", 16'(pc), 16'h00);
    step();
    check("t5_err_pulse", 16'(fetch_error), 16'd0);
    check("t5_retry_en", 16'(bus.mem_en), 16'd1);
    check("t5_retry_addr", 16'(bus.mem_address), 16'h00);
    check("t5_nv", 16'(instr_valid), 16'd0);
    stuck = 1'b0;
    push(8'h00);
    wait_valid();

    instr_accept = 1'b0;
    halt         = 1'b1;
    step();
    check("t6_hold", 16'(instr_valid), 16'd1);
    instr_accept = 1'b1;
    step();
    check("t6_idle_halted", 16'(halted), 16'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t6_halted", 16'(halted), 16'd1);
      check("t6_en", 16'(bus.mem_en), 16'd0);
    end
    pc_load       = 1'b1;
    pc_load_value = 8'h0C;
    halt          = 1'b0;
    step();
    pc_load = 1'b0;
    check("t6_resume", 16'(halted), 16'd0);
    check("t6_pc", 16'(pc), 16'h0C);
    wait_req(8'h0C);
    push(8'h0C);
    wait_valid();

    for (int i = 0; i < 4; i++) step();
    check("sb_drained", 16'(sb.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
